// File: rtl/gem_fiber_rx_frame.sv
// GEM trigger fiber receive back-end: finds 2-word frame alignment, locks, rebuilds
// the 56-bit cluster word, decodes BX/overflow from the separator and counts errors.
module gem_fiber_rx_frame #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned UNLOCK_ERRS = 3
) (
  input  logic        TRG_CLK80,
  input  logic        TRG_RST,
  input  logic [31:0] RX_DATA,
  input  logic [3:0]  RX_ISK,
  input  logic        CNT_RESET,
  output logic [55:0] GEM_DATA,
  output logic        GEM_OVERFLOW,
  output logic [1:0]  BX_LSB,
  output logic        DATA_VALID,
  output logic        LOCKED,
  output logic        SYNC_RESET_SEEN,
  output logic [1:0]  STATE,
  output logic [15:0] FRAME_ERR_CNT,
  output logic [15:0] SEQ_ERR_CNT
);

  typedef enum logic [1:0] {ST_HUNT = 2'd0, ST_SYNC = 2'd1, ST_LOCK = 2'd2} state_t;
  typedef enum logic [1:0] {CL_IDLE, CL_SEP, CL_DAT, CL_BAD} cls_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  state_t      state_q, state_d;
  logic        phase_b_q, phase_b_d;
  logic [31:0] a_word_q, a_word_d;
  logic        a_ok_q, a_ok_d;
  logic        prev_dat_q, prev_dat_d;
  logic        prev_idle_q, prev_idle_d;
  logic [3:0]  good_run_q, good_run_d;
  logic [3:0]  bad_run_q, bad_run_d;
  logic [1:0]  exp_bx_q, exp_bx_d;
  logic [55:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  bx_q, bx_d;
  logic        valid_q, valid_d;
  logic        sync_seen_q, sync_seen_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] seq_cnt_q, seq_cnt_d;

  cls_t       cls;
  logic [1:0] sep_bx;
  logic       sep_ovf;
  logic       frame_good;
  logic       frame_inc;
  logic       seq_inc;

  always_comb begin
    cls     = CL_BAD;
    sep_bx  = 2'd0;
    sep_ovf = 1'b0;
    if (RX_ISK == 4'b0101 && RX_DATA == 32'h50BC50BC) begin
      cls = CL_IDLE;
    end else if (RX_ISK == 4'b0000) begin
      cls = CL_DAT;
    end else if (RX_ISK == 4'b0001) begin
      cls = CL_SEP;
      case (RX_DATA[7:0])
        8'hBC:   sep_bx = 2'd0;
        8'hF7:   sep_bx = 2'd1;
        8'hFB:   sep_bx = 2'd2;
        8'hFD:   sep_bx = 2'd3;
        8'hFC:   sep_ovf = 1'b1;
        default: cls = CL_BAD;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_b_d   = phase_b_q;
    a_word_d    = a_word_q;
    a_ok_d      = a_ok_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    exp_bx_d    = exp_bx_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    bx_d        = bx_q;
    valid_d     = 1'b0;
    frame_good  = 1'b0;
    frame_inc   = 1'b0;
    seq_inc     = 1'b0;
    prev_dat_d  = (cls == CL_DAT);
    prev_idle_d = (cls == CL_IDLE);
    sync_seen_d = (cls == CL_IDLE) && !prev_idle_q;

    if (cls == CL_IDLE) begin
      state_d    = ST_HUNT;
      phase_b_d  = 1'b0;
      good_run_d = 4'd0;
      bad_run_d  = 4'd0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          // A separator right after a data word marks a candidate frame boundary.
          if (cls == CL_SEP && prev_dat_q) begin
            state_d    = ST_SYNC;
            good_run_d = 4'd1;
            phase_b_d  = 1'b0;
            exp_bx_d   = sep_ovf ? 2'd0 : sep_bx + 2'd1;
          end
        end
        default: begin
          if (!phase_b_q) begin
            a_word_d  = RX_DATA;
            a_ok_d    = (cls == CL_DAT);
            phase_b_d = 1'b1;
          end else begin
            phase_b_d  = 1'b0;
            frame_good = a_ok_q && (cls == CL_SEP);
            if (!frame_good) begin
              frame_inc = 1'b1;
              if (state_q == ST_SYNC) begin
                state_d    = ST_HUNT;
                good_run_d = 4'd0;
              end else begin
                bad_run_d = bad_run_q + 4'd1;
                if (bad_run_d >= UNLOCK_N) begin
                  state_d    = ST_HUNT;
                  bad_run_d  = 4'd0;
                  good_run_d = 4'd0;
                end
              end
            end else begin
              // Expected BX tracks good frames while syncing so the first locked frame checks cleanly.
              exp_bx_d = sep_ovf ? exp_bx_q + 2'd1 : sep_bx + 2'd1;
              if (state_q == ST_SYNC) begin
                good_run_d = good_run_q + 4'd1;
                if (good_run_d >= LOCK_N) begin
                  state_d   = ST_LOCK;
                  bad_run_d = 4'd0;
                end
              end else begin
                bad_run_d = 4'd0;
                valid_d   = 1'b1;
                data_d    = {a_word_q, RX_DATA[31:8]};
                ovf_d     = sep_ovf;
                bx_d      = sep_ovf ? exp_bx_q : sep_bx;
                seq_inc   = !sep_ovf && (sep_bx != exp_bx_q);
              end
            end
          end
        end
      endcase
    end

    frame_cnt_d = frame_cnt_q;
    seq_cnt_d   = seq_cnt_q;
    if (CNT_RESET) begin
      frame_cnt_d = 16'd0;
      seq_cnt_d   = 16'd0;
    end else begin
      if (frame_inc && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
      if (seq_inc && seq_cnt_q != 16'hFFFF) seq_cnt_d = seq_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge TRG_CLK80) begin
    if (TRG_RST) begin
      state_q     <= ST_HUNT;
      phase_b_q   <= 1'b0;
      a_word_q    <= 32'd0;
      a_ok_q      <= 1'b0;
      prev_dat_q  <= 1'b0;
      prev_idle_q <= 1'b0;
      good_run_q  <= 4'd0;
      bad_run_q   <= 4'd0;
      exp_bx_q    <= 2'd0;
      data_q      <= 56'd0;
      ovf_q       <= 1'b0;
      bx_q        <= 2'd0;
      valid_q     <= 1'b0;
      sync_seen_q <= 1'b0;
      frame_cnt_q <= 16'd0;
      seq_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      phase_b_q   <= phase_b_d;
      a_word_q    <= a_word_d;
      a_ok_q      <= a_ok_d;
      prev_dat_q  <= prev_dat_d;
      prev_idle_q <= prev_idle_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      exp_bx_q    <= exp_bx_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      bx_q        <= bx_d;
      valid_q     <= valid_d;
      sync_seen_q <= sync_seen_d;
      frame_cnt_q <= frame_cnt_d;
      seq_cnt_q   <= seq_cnt_d;
    end
  end

  assign GEM_DATA        = data_q;
  assign GEM_OVERFLOW    = ovf_q;
  assign BX_LSB          = bx_q;
  assign DATA_VALID      = valid_q;
  assign LOCKED          = (state_q == ST_LOCK);
  assign SYNC_RESET_SEEN = sync_seen_q;
  assign STATE           = state_q;
  assign FRAME_ERR_CNT   = frame_cnt_q;
  assign SEQ_ERR_CNT     = seq_cnt_q;

endmodule
